cobs_cmd_sequencer: RTL and testbench
=====================================

Name: cobs_cmd_sequencer

Overview:
- Command controller between the COBS-decoded UART byte stream and the frame-buffer write port.
- Parses each decoded frame as one command packet and issues single-byte writes to the frame-buffer write arbiter.
- Handles req/ack, applies back-pressure (busy) to the decoder, reports packet completion and errors.

Parameters:
- ADDR_W, 24, write address width; header address truncated to ADDR_W LSBs, increments wrap modulo 2^ADDR_W.
- LEN_W, 16, payload/fill length counter width; header length fixed 16 bits.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-low
- in_valid  in  1  one-cycle pulse: decoded byte on in_data
- in_data  in  8  decoded byte
- in_eof  in  1  one-cycle pulse: frame delimiter (0x00) seen
- busy  out  1  high = byte not accepted; producer must not pulse in_valid
- wr_req  out  1  write request, held until wr_ack
- wr_addr  out  ADDR_W  write address, stable while wr_req
- wr_data  out  8  write data, stable while wr_req
- wr_ack  in  1  write accepted (sampled only while wr_req=1)
- pkt_done  out  1  one-cycle pulse: packet completed without error
- pkt_err  out  1  one-cycle pulse: packet aborted/flagged
- err_code  out  2  valid with pkt_err: 1 bad cmd, 2 short frame, 3 overrun/dropped byte; holds last value

Behaviour:
- Reset (RST=0 at CLK edge): state IDLE; busy, wr_req, pkt_done, pkt_err = 0; err_code, wr_addr, wr_data = 0; counters cleared. Reset mid-write drops wr_req next edge; write port tolerates abandoned request.
- Packet: CMD, A2, A1, A0 (address MSB first), L1, L0 (length MSB first), then payload.
- CMD 0x01 WRITE: LEN payload bytes written to addr, addr+1, ...
- CMD 0x02 FILL: one payload byte written LEN times from addr upward.
- States:
  - IDLE: byte = CMD. 0x01/0x02 -> HDR. Else pkt_err code 1 -> DRAIN.
  - HDR: 5 bytes via counter 0..4, then:
    - WRITE, LEN>0 -> DATA.
    - WRITE, LEN=0 -> TAIL.
    - FILL -> FILLB.
  - DATA: each byte -> latch wr_data/wr_addr, wr_req=1, busy=1, -> ACK.
  - ACK: on wr_ack: wr_req=0 next cycle, addr+1, remaining-1. remaining=0 -> TAIL. WRITE -> DATA, busy=0. FILL -> next write.
  - FILLB: fill byte latched. LEN=0 -> TAIL. Else busy=1, issue writes back-to-back; each new wr_req asserts the cycle after the previous ack.
  - TAIL: all data consumed; await eof. eof -> pkt_done -> IDLE. Extra byte -> pkt_err code 3 -> DRAIN.
  - DRAIN: discard bytes until eof -> IDLE (no further pulse).
- Latency:
  - Byte accepted in DATA -> wr_req high next cycle.
  - Final ack -> pkt_done at earliest 1 cycle after eof is seen in TAIL.
- busy: high in ACK and during FILL writes; low otherwise.
- Boundary conditions:
  - in_valid while busy: byte dropped, pkt_err code 3 once writes in flight finish, then DRAIN.
  - eof in IDLE: ignored (empty frame).
  - eof in HDR/DATA/FILLB: pkt_err code 2 -> IDLE.
  - eof during ACK with remaining>0 (WRITE): outstanding write completes, then pkt_err code 2.
  - eof during FILL writes: remaining fill writes complete; pkt_done after last ack.
  - in_valid and in_eof same cycle: byte processed first; eof acts as if next cycle.
  - Address wrap: 0xFFFFFF + 1 -> 0x000000 (ADDR_W=24).
  - pkt_done and pkt_err never assert together.

Optional Feature:
- Macro CMDSEQ_ERRCNT_EN.
- Defined: extra output err_count [7:0]. Increments on each pkt_err, saturates at 0xFF, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Frame 01 00 10 00 00 03 AA BB CC + eof, wr_ack 2 cycles after req -> writes (0x001000,AA),(0x001001,BB),(0x001002,CC); pkt_done 1 pulse; busy high only during ACK.
- Frame 02 00 00 FE 00 04 55 + eof, immediate ack -> 4 writes of 0x55 at 0xFE..0x101, back-to-back, busy high throughout; pkt_done.
- Frame 01 FF FF FF 00 02 11 22 + eof -> addresses 0xFFFFFF then 0x000000.
- Frame 07 12 34 + eof -> pkt_err code 1, no wr_req, IDLE after eof. Frame 01 00 00 00 00 02 11 + eof -> one write, pkt_err code 2.
- WRITE LEN=1 with two payload bytes -> one write, pkt_err code 3. in_valid pulsed while busy -> code 3, no write for dropped byte.
- RST low while wr_req high -> next edge all outputs 0, state IDLE. Next valid frame completes normally. With CMDSEQ_ERRCNT_EN, 300 bad frames -> err_count=0xFF.

Source files
------------

// File: rtl/cobs_cmd_sequencer.sv
// Command sequencer: parses COBS-decoded frames (WRITE/FILL) into single-byte frame-buffer writes.
// Optional build macro CMDSEQ_ERRCNT_EN adds a saturating err_count output.
module cobs_cmd_sequencer #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned LEN_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_eof,
    output logic              busy,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ack,
    output logic              pkt_done,
    output logic              pkt_err,
    output logic [1:0]        err_code
`ifdef CMDSEQ_ERRCNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_FILL  = 8'h02;
    localparam logic [1:0] ERR_CMD   = 2'd1;
    localparam logic [1:0] ERR_SHORT = 2'd2;
    localparam logic [1:0] ERR_OVR   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_DATA, S_ACK, S_FILLB, S_FILL, S_TAIL, S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [2:0]        hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [7:0]        fbyte_q, fbyte_d;
    logic              fill_q, fill_d;
    logic              eof_pend_q, eof_pend_d;
    logic              eof_seen_q, eof_seen_d;
    logic              drop_seen_q, drop_seen_d;

    logic              busy_d, wr_req_d, pkt_done_d, pkt_err_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [7:0]        wr_data_d;
    logic [1:0]        err_code_d;

    logic              fin_ok, fin_err;
    logic [1:0]        fin_code;

    // An eof arriving with a byte is deferred one cycle so the byte is handled first.
    logic              eof_now_c, ack_c, eof_any_c, drop_any_c;
    logic [LEN_W-1:0]  rem_shift_c, rem_dec_c;

    assign eof_now_c   = !in_valid && (in_eof || eof_pend_q);
    assign ack_c       = wr_req && wr_ack;
    assign eof_any_c   = eof_seen_q || eof_now_c;
    assign drop_any_c  = drop_seen_q || in_valid;
    assign rem_shift_c = {rem_q[LEN_W-9:0], in_data};
    assign rem_dec_c   = rem_q - LEN_W'(1);

    always_ff @(posedge CLK) begin : state_reg
        if (!RST) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin : next_state
        state_d  = state_q;
        fin_ok   = 1'b0;
        fin_err  = 1'b0;
        fin_code = 2'd0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_data == CMD_WRITE || in_data == CMD_FILL) begin
                        state_d = S_HDR;
                    end else begin
                        fin_err  = 1'b1;
                        fin_code = ERR_CMD;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_HDR: begin
                if (in_valid) begin
                    if (hdr_cnt_q == 3'd4) begin
                        if (fill_q)                state_d = S_FILLB;
                        else if (rem_shift_c == '0) state_d = S_TAIL;
                        else                       state_d = S_DATA;
                    end
                end else if (eof_now_c) begin
                    fin_err  = 1'b1;
                    fin_code = ERR_SHORT;
                    state_d  = S_IDLE;
                end
            end
            S_DATA, S_FILLB: begin
                if (in_valid) begin
                    state_d = (state_q == S_FILLB && rem_q == '0) ? S_TAIL : S_ACK;
                end else if (eof_now_c) begin
                    fin_err  = 1'b1;
                    fin_code = ERR_SHORT;
                    state_d  = S_IDLE;
                end
            end
            S_ACK: begin
                // Dropped bytes outrank a short frame; a seen eof means no drain is needed.
                if (ack_c) begin
                    if (drop_any_c && (rem_dec_c == '0 || !fill_q)) begin
                        fin_err  = 1'b1;
                        fin_code = ERR_OVR;
                        state_d  = eof_any_c ? S_IDLE : S_DRAIN;
                    end else if (rem_dec_c == '0) begin
                        fin_ok  = eof_any_c;
                        state_d = eof_any_c ? S_IDLE : S_TAIL;
                    end else if (!fill_q && eof_any_c) begin
                        fin_err  = 1'b1;
                        fin_code = ERR_SHORT;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = fill_q ? S_FILL : S_DATA;
                    end
                end
            end
            S_FILL: state_d = S_ACK;
            S_TAIL: begin
                if (in_valid) begin
                    fin_err  = 1'b1;
                    fin_code = ERR_OVR;
                    state_d  = S_DRAIN;
                end else if (eof_now_c) begin
                    fin_ok  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: if (eof_now_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin : output_next
        hdr_cnt_d   = hdr_cnt_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        fbyte_d     = fbyte_q;
        fill_d      = fill_q;
        eof_seen_d  = eof_seen_q;
        drop_seen_d = drop_seen_q;
        eof_pend_d  = in_valid && (in_eof || eof_pend_q);
        busy_d      = busy;
        wr_req_d    = wr_req;
        wr_addr_d   = wr_addr;
        wr_data_d   = wr_data;
        pkt_done_d  = fin_ok;
        pkt_err_d   = fin_err;
        err_code_d  = fin_err ? fin_code : err_code;
        case (state_q)
            S_IDLE: begin
                eof_seen_d  = 1'b0;
                drop_seen_d = 1'b0;
                if (in_valid) begin
                    fill_d    = (in_data == CMD_FILL);
                    hdr_cnt_d = 3'd0;
                    addr_d    = '0;
                    rem_d     = '0;
                end
            end
            S_HDR: begin
                if (in_valid) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q < 3'd3) addr_d = {addr_q[ADDR_W-9:0], in_data};
                    else                  rem_d  = rem_shift_c;
                end
            end
            S_DATA, S_FILLB: begin
                if (in_valid) begin
                    fbyte_d = in_data;
                    if (state_q == S_DATA || rem_q != '0) begin
                        wr_req_d  = 1'b1;
                        busy_d    = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = in_data;
                    end
                end
            end
            S_ACK: begin
                if (in_valid)  drop_seen_d = 1'b1;
                if (eof_now_c) eof_seen_d  = 1'b1;
                if (ack_c) begin
                    wr_req_d = 1'b0;
                    addr_d   = addr_q + ADDR_W'(1);
                    rem_d    = rem_dec_c;
                    busy_d   = (state_d == S_FILL);
                end
            end
            S_FILL: begin
                if (in_valid)  drop_seen_d = 1'b1;
                if (eof_now_c) eof_seen_d  = 1'b1;
                wr_req_d  = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = fbyte_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin : data_reg
        if (!RST) begin
            hdr_cnt_q   <= '0;
            addr_q      <= '0;
            rem_q       <= '0;
            fbyte_q     <= '0;
            fill_q      <= 1'b0;
            eof_pend_q  <= 1'b0;
            eof_seen_q  <= 1'b0;
            drop_seen_q <= 1'b0;
            busy        <= 1'b0;
            wr_req      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            pkt_done    <= 1'b0;
            pkt_err     <= 1'b0;
            err_code    <= '0;
        end else begin
            hdr_cnt_q   <= hdr_cnt_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            fbyte_q     <= fbyte_d;
            fill_q      <= fill_d;
            eof_pend_q  <= eof_pend_d;
            eof_seen_q  <= eof_seen_d;
            drop_seen_q <= drop_seen_d;
            busy        <= busy_d;
            wr_req      <= wr_req_d;
            wr_addr     <= wr_addr_d;
            wr_data     <= wr_data_d;
            pkt_done    <= pkt_done_d;
            pkt_err     <= pkt_err_d;
            err_code    <= err_code_d;
        end
    end

`ifdef CMDSEQ_ERRCNT_EN
    // Saturating count of flagged packets.
    always_ff @(posedge CLK) begin : err_cnt_reg
        if (!RST)                               err_count <= '0;
        else if (pkt_err_d && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
`endif

endmodule

// File: tb/tb_cobs_cmd_sequencer.sv
// Directed bench for cobs_cmd_sequencer: frames, ack responder, negedge monitor and scoreboard.
// Build with CMDSEQ_ERRCNT_EN defined to also exercise err_count saturation.
module tb_cobs_cmd_sequencer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_eof = 1'b0;
    logic        busy;
    logic        wr_req;
    logic [23:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack = 1'b0;
    logic        pkt_done;
    logic        pkt_err;
    logic [1:0]  err_code;
`ifdef CMDSEQ_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    cobs_cmd_sequencer #(.ADDR_W(24), .LEN_W(16)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_data(in_data), .in_eof(in_eof),
        .busy(busy), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
`ifdef CMDSEQ_ERRCNT_EN
        , .err_count(err_count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Ack responder: acks after ack_dly idle negedges and logs the accepted write.
    int          ack_dly  = 0;
    int          ack_wait = 0;
    logic [23:0] wa_q[$];
    logic [7:0]  wd_q[$];

    always @(negedge CLK) begin
        if (!RST) begin
            wr_ack   = 1'b0;
            ack_wait = 0;
        end else if (wr_req && !wr_ack) begin
            if (ack_wait >= ack_dly) begin
                wr_ack   = 1'b1;
                ack_wait = 0;
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
            end else begin
                ack_wait++;
            end
        end else begin
            wr_ack = 1'b0;
        end
    end

    int         done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int         busy_cyc = 0, req_cyc = 0, busy_mis = 0;
    logic [1:0] last_code = 2'd0;

    always @(negedge CLK) begin
        if (RST) begin
            if (pkt_done) done_cnt++;
            if (pkt_err) begin
                err_cnt++;
                last_code = err_code;
            end
            if (pkt_done && pkt_err) both_cnt++;
            if (busy)   busy_cyc++;
            if (wr_req) req_cyc++;
            if (busy != wr_req) busy_mis++;
        end
    end

    int b_done, b_err, b_busy, b_req, b_mis, b_wr;

    task automatic mark();
        b_done = done_cnt; b_err = err_cnt; b_busy = busy_cyc;
        b_req  = req_cyc;  b_mis = busy_mis; b_wr  = wa_q.size();
    endtask

    function automatic logic [31:0] wr_at(input int i);
        if (i < wa_q.size()) return {wa_q[i], wd_q[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic wait_not_busy();
        int n = 0;
        while (busy && n < 500) begin
            @(posedge CLK); #1;
            n++;
        end
        if (busy) check("busy_timeout", 32'(busy), 32'h0);
    endtask

    task automatic send_raw(input logic [7:0] b, input logic eof);
        in_valid = 1'b1; in_data = b; in_eof = eof;
        @(posedge CLK); #1;
        in_valid = 1'b0; in_eof = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        wait_not_busy();
        send_raw(b, 1'b0);
    endtask

    task automatic send_eof();
        in_eof = 1'b1;
        @(posedge CLK); #1;
        in_eof = 1'b0;
    endtask

    logic [7:0] frm[$];

    task automatic send_bytes();
        foreach (frm[i]) send_byte(frm[i]);
    endtask

    task automatic settle();
        int n = 0;
        while ((busy || wr_req) && n < 500) begin
            @(posedge CLK); #1;
            n++;
        end
        if (busy || wr_req) check("settle_timeout", {busy, wr_req}, 32'h0);
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic frame(input int dly);
        ack_dly = dly;
        mark();
        send_bytes();
        send_eof();
        settle();
    endtask

    initial begin
        RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy",   32'(busy), 32'h0);
        check("rst_wr_req", 32'(wr_req), 32'h0);
        check("rst_pulses", {pkt_done, pkt_err}, 32'h0);
        check("rst_code",   32'(err_code), 32'h0);
        check("rst_wraddr", {wr_addr, wr_data}, 32'h0);
`ifdef CMDSEQ_ERRCNT_EN
        check("rst_errcnt", 32'(err_count), 32'h0);
`endif
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Eof in IDLE is an empty frame.
        mark();
        send_eof();
        settle();
        check("empty_pulses", done_cnt - b_done + err_cnt - b_err, 32'h0);

        frm = '{8'h01, 8'h00, 8'h10, 8'h00, 8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        frame(2);
        check("wr_n",     wa_q.size() - b_wr, 32'd3);
        check("wr0",      wr_at(b_wr),     32'h001000AA);
        check("wr1",      wr_at(b_wr + 1), 32'h001001BB);
        check("wr2",      wr_at(b_wr + 2), 32'h001002CC);
        check("wr_done",  done_cnt - b_done, 32'd1);
        check("wr_err",   err_cnt - b_err, 32'd0);
        check("wr_busy",  busy_mis - b_mis, 32'd0);
        check("wr_reqcy", req_cyc - b_req, 32'd9);

        // Fill with eof sent while writes are still in flight.
        ack_dly = 0;
        mark();
        frm = '{8'h02, 8'h00, 8'h00, 8'hFE, 8'h00, 8'h04, 8'h55};
        send_bytes();
        send_eof();
        settle();
        check("fill_n",    wa_q.size() - b_wr, 32'd4);
        check("fill0",     wr_at(b_wr),     32'h0000FE55);
        check("fill1",     wr_at(b_wr + 1), 32'h0000FF55);
        check("fill2",     wr_at(b_wr + 2), 32'h00010055);
        check("fill3",     wr_at(b_wr + 3), 32'h00010155);
        check("fill_busy", busy_cyc - b_busy, 32'd7);
        check("fill_req",  req_cyc - b_req, 32'd4);
        check("fill_done", done_cnt - b_done, 32'd1);

        frm = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h22};
        frame(1);
        check("wrap0",    wr_at(b_wr),     32'hFFFFFF11);
        check("wrap1",    wr_at(b_wr + 1), 32'h00000022);
        check("wrap_done", done_cnt - b_done, 32'd1);

        frm = '{8'h07, 8'h12, 8'h34};
        frame(0);
        check("badcmd_err",  err_cnt - b_err, 32'd1);
        check("badcmd_code", 32'(last_code), 32'd1);
        check("badcmd_req",  req_cyc - b_req, 32'd0);

        frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h11};
        frame(1);
        check("short_n",    wa_q.size() - b_wr, 32'd1);
        check("short_err",  err_cnt - b_err, 32'd1);
        check("short_code", 32'(last_code), 32'd2);
        check("short_done", done_cnt - b_done, 32'd0);

        frm = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h11, 8'h22};
        frame(1);
        check("extra_n",    wa_q.size() - b_wr, 32'd1);
        check("extra_code", 32'(last_code), 32'd3);
        check("extra_err",  err_cnt - b_err, 32'd1);

        // Byte pushed while busy is dropped; eof follows during the same write.
        ack_dly = 2;
        mark();
        frm = '{8'h01, 8'h00, 8'h00, 8'h20, 8'h00, 8'h02, 8'h11};
        send_bytes();
        send_raw(8'h22, 1'b0);
        send_eof();
        settle();
        check("drop_n",    wa_q.size() - b_wr, 32'd1);
        check("drop_wr",   wr_at(b_wr), 32'h00002011);
        check("drop_code", 32'(last_code), 32'd3);
        check("drop_err",  err_cnt - b_err, 32'd1);

        // Reset while a write is pending.
        ack_dly = 40;
        mark();
        frm = '{8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'h01, 8'h77};
        send_bytes();
        check("rst_mid_req", 32'(wr_req), 32'h1);
        RST = 1'b0;
        @(posedge CLK); #1;
        check("rst_mid_outs", {busy, wr_req, pkt_done, pkt_err, err_code}, 32'h0);
        check("rst_mid_bus",  {wr_addr, wr_data}, 32'h0);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        frm = '{8'h01, 8'h00, 8'h00, 8'h50, 8'h00, 8'h01, 8'h99};
        frame(0);
        check("post_rst_wr",   wr_at(b_wr), 32'h00005099);
        check("post_rst_done", done_cnt - b_done, 32'd1);

        // Last byte and eof in the same cycle.
        ack_dly = 1;
        mark();
        frm = '{8'h01, 8'h00, 8'h00, 8'h60, 8'h00, 8'h01};
        send_bytes();
        wait_not_busy();
        send_raw(8'hAB, 1'b1);
        settle();
        check("coeof_wr",   wr_at(b_wr), 32'h000060AB);
        check("coeof_done", done_cnt - b_done, 32'd1);
        check("coeof_err",  err_cnt - b_err, 32'd0);

        frm = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h33};
        frame(0);
        check("fill0_n",    wa_q.size() - b_wr, 32'd0);
        check("fill0_done", done_cnt - b_done, 32'd1);

`ifdef CMDSEQ_ERRCNT_EN
        frm = '{8'h07};
        for (int k = 0; k < 300; k++) begin
            send_byte(8'h07);
            send_eof();
        end
        settle();
        check("errcnt_sat", 32'(err_count), 32'hFF);
`endif

        check("done_err_overlap", both_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
